load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Sits directly upstream of DataMemory, between the core's execute stage and the memory port (clk, WE, A, WD, RD).
- Accepts byte-addressed load/store requests over a valid/ready handshake.
- Converts byte addresses to DataMemory word indices.
- Performs read-modify-write for byte/halfword stores and sign/zero-extends loads.
- Flags misaligned or illegal accesses without touching memory.

Parameters:
- ADDR_W, 32, width of the core byte address and of the DataMemory A port.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  LSU can accept; a request is accepted on req_valid && req_ready at a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned (bits [7:0] for byte, [15:0] for half).
- rsp_valid  out  1  one-cycle pulse; response complete.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid; 1 = misaligned or illegal size.
- mem_we  out  1  to DataMemory WE.
- mem_a  out  ADDR_W  to DataMemory A; word index = {2'b00, addr[31:2]}.
- mem_wd  out  DATA_W  to DataMemory WD.
- mem_rd  in  DATA_W  from DataMemory RD; combinational read of RAM[mem_a].

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - req_ready = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, mem_we = 0, mem_a = 0, mem_wd = 0.
  - mem_we is decoded from state, so it drops immediately on reset assertion.
- Request capture: on accept, register req_we, req_size, req_unsigned, req_addr and req_wdata. Core inputs are ignored outside IDLE.
- Error check, evaluated on the captured request:
  - size = 11 → error.
  - half with addr[0] = 1 → error.
  - word with addr[1:0] ≠ 00 → error.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE: req_ready = 1. On accept:
    - error → RESP;
    - load → READ;
    - word store → WRITE;
    - byte/half store → READ.
  - READ: mem_a = word index, mem_we = 0. Register mem_rd into old_word. Then load → RESP, sub-word store → WRITE.
  - WRITE: mem_we = 1 for exactly this cycle; mem_a = word index.
    - Word store: mem_wd = wdata.
    - Sub-word store: mem_wd = old_word with the selected byte lane(s) replaced. Byte lane = addr[1:0]; half lane = addr[1]. Little-endian.
    - Then → RESP.
  - RESP: rsp_valid = 1 for one cycle, then → IDLE. req_ready = 0 in this cycle.
- Load extraction: byte = old_word[8*addr[1:0] +: 8]; half = old_word[16*addr[1] +: 16]; extend per req_unsigned. Word loads are passed through.
- Latency (accept edge to rsp_valid high):
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Throughput: the next accept can occur in the cycle after RESP. Holding req_valid high gives one request per 3–4 cycles.
- Outside READ/WRITE: mem_a holds its last value and mem_we = 0.
- rsp_rdata and rsp_err hold until the next RESP; they are only meaningful while rsp_valid = 1.
- Reset mid-operation:
  - Any in-flight request is discarded and no rsp_valid is produced.
  - If reset asserts during WRITE before the edge, the write is not performed.
- Error requests never assert mem_we and never enter READ.

Decomposition:
- Shared package lsu_pkg:
  - size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  - FSM state encodings;
  - function word_index(addr).
- Sub-module lsu_align (combinational):
  - inputs: size, unsigned, addr[1:0], old_word, wdata;
  - outputs: extended load data, merged store word, misaligned flag.
  - The FSM, registers and handshake stay in load_store_unit.

Test Plan:
- Load word with RAM[0x200] preloaded to 10: req_addr = 0x800, size = word → mem_a = 0x200 in READ; rsp_valid 2 cycles after accept; rsp_rdata = 0x0000000A, rsp_err = 0.
- Store byte 0xFF to 0x801, then load byte signed 0x801 → 0xFFFFFFFF; load byte unsigned 0x801 → 0x000000FF; load word 0x800 → 0x0000FF0A. The store shows mem_we high for exactly one cycle, 2 cycles after accept.
- Store half 0xBEEF to 0x802, then load half signed 0x802 → 0xFFFFBEEF; load word 0x800 → 0xBEEFFF0A.
- Misaligned: half at 0x803, word at 0x802, size = 11 at 0x800 → each gives rsp_valid 1 cycle after accept with rsp_err = 1 and rsp_rdata = 0; mem_we never high; RAM[0x200] unchanged.
- Reset mid-op: issue a sub-word store and assert rst_n = 0 during READ → mem_we stays 0, no rsp_valid, RAM unchanged; after release, req_ready = 1 and a fresh load succeeds.
- Back-to-back: req_valid held high with three loads → accepts are spaced exactly 3 cycles apart, each followed by one rsp_valid pulse with the correct data.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - size encodings for the request size field
//   - FSM state encoding
//   - word_index(): byte address -> DataMemory word index
package lsu_pkg;

    localparam int LSU_ADDR_W = 32;
    localparam int LSU_DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    // DataMemory is word addressed: drop the byte offset.
    function automatic logic [LSU_ADDR_W-1:0] word_index(input logic [LSU_ADDR_W-1:0] addr);
        return {2'b00, addr[LSU_ADDR_W-1:2]};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the load/store unit.
// Ports:
//   size       in  2   request size (byte/half/word/illegal)
//   uns        in  1   1 = zero-extend loads, 0 = sign-extend
//   addr_lo    in  2   byte offset within the word
//   old_word   in  32  word read from memory
//   wdata      in  32  right-aligned store data
//   load_data  out 32  extracted and extended load value
//   store_word out 32  old_word with the addressed lane(s) replaced
//   misaligned out 1   misaligned access or illegal size
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic        misaligned
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = old_word[{addr_lo, 3'b000} +: 8];
        half_val = old_word[{addr_lo[1], 4'b0000} +: 16];
    end

    always_comb begin
        load_data = old_word;
        case (size)
            SZ_BYTE: load_data = uns ? {24'h000000, byte_val} : {{24{byte_val[7]}}, byte_val};
            SZ_HALF: load_data = uns ? {16'h0000, half_val} : {{16{half_val[15]}}, half_val};
            default: load_data = old_word;
        endcase
    end

    // Illegal size is folded into the same error flag as misalignment.
    always_comb begin
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = addr_lo[0];
            SZ_WORD: misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Little-endian byte lanes: each lane picks either the new store byte
    // or keeps the byte already in memory.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       lane_en;
            logic [7:0] lane_src;

            always_comb begin
                lane_en  = 1'b0;
                lane_src = wdata[8*gi +: 8];
                case (size)
                    SZ_BYTE: begin
                        lane_en  = (addr_lo == LANE);
                        lane_src = wdata[7:0];
                    end
                    SZ_HALF: begin
                        lane_en  = (addr_lo[1] == LANE[1]);
                        lane_src = wdata[8*(gi%2) +: 8];
                    end
                    SZ_WORD: lane_en = 1'b1;
                    default: lane_en = 1'b0;
                endcase
            end

            assign store_word[8*gi +: 8] = lane_en ? lane_src : old_word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store front end for a word-wide
// DataMemory with combinational read.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (accept on both high)
//   req_we, req_size, req_unsigned  store flag, size, load extension mode
//   req_addr, req_wdata             byte address, right-aligned store data
//   rsp_valid                       one-cycle completion pulse
//   rsp_rdata, rsp_err              load data / error flag, valid with rsp_valid
//   mem_we, mem_a, mem_wd, mem_rd   DataMemory port (word-indexed)
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    lsu_state_t        state_reg, state_next;
    logic              we_reg;
    logic [1:0]        size_reg;
    logic              uns_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] old_word_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic              rsp_err_reg;
    logic [ADDR_W-1:0] mem_a_hold_reg;
    logic [DATA_W-1:0] mem_wd_hold_reg;

    logic              accept;
    logic [1:0]        al_size;
    logic [1:0]        al_addr_lo;
    logic [DATA_W-1:0] al_word;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_word;
    logic              misaligned;

    // Ready is gated by rst_n so it reads 0 while reset is held.
    assign req_ready = (state_reg == ST_IDLE) && rst_n;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;
    assign mem_we    = (state_reg == ST_WRITE);

    // In IDLE the aligner checks the live request so the error decision
    // is made on the accept edge; afterwards it sees the captured copy.
    // In READ the load is extracted straight from mem_rd so the response
    // can be registered on the READ->RESP edge.
    always_comb begin
        al_size    = size_reg;
        al_addr_lo = addr_reg[1:0];
        al_word    = old_word_reg;
        if (state_reg == ST_IDLE) begin
            al_size    = req_size;
            al_addr_lo = req_addr[1:0];
        end
        if (state_reg == ST_READ) begin
            al_word = mem_rd;
        end
    end

    lsu_align u_align (
        .size       (al_size),
        .uns        (uns_reg),
        .addr_lo    (al_addr_lo),
        .old_word   (al_word),
        .wdata      (wdata_reg),
        .load_data  (load_data),
        .store_word (store_word),
        .misaligned (misaligned)
    );

    // Memory address/data only change while the FSM owns the port; otherwise
    // they hold the last driven value.
    always_comb begin
        mem_a  = mem_a_hold_reg;
        mem_wd = mem_wd_hold_reg;
        if (state_reg == ST_READ || state_reg == ST_WRITE) begin
            mem_a = word_index(addr_reg);
        end
        if (state_reg == ST_WRITE) begin
            mem_wd = store_word;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (misaligned)             state_next = ST_RESP;
                    else if (!req_we)           state_next = ST_READ;
                    else if (req_size == SZ_WORD) state_next = ST_WRITE;
                    else                        state_next = ST_READ;
                end
            end
            ST_READ:  state_next = we_reg ? ST_WRITE : ST_RESP;
            ST_WRITE: state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            we_reg          <= 1'b0;
            size_reg        <= SZ_BYTE;
            uns_reg         <= 1'b0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            old_word_reg    <= '0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            mem_a_hold_reg  <= '0;
            mem_wd_hold_reg <= '0;
        end else begin
            state_reg       <= state_next;
            mem_a_hold_reg  <= mem_a;
            mem_wd_hold_reg <= mem_wd;
            if (accept) begin
                we_reg    <= req_we;
                size_reg  <= req_size;
                uns_reg   <= req_unsigned;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                if (misaligned) begin
                    rsp_rdata_reg <= '0;
                    rsp_err_reg   <= 1'b1;
                end
            end
            if (state_reg == ST_READ) begin
                old_word_reg <= mem_rd;
                if (!we_reg) begin
                    rsp_rdata_reg <= load_data;
                    rsp_err_reg   <= 1'b0;
                end
            end
            if (state_reg == ST_WRITE) begin
                rsp_rdata_reg <= '0;
                rsp_err_reg   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] ram [0:1023];
    logic        preload;

    int n_cmp;
    int n_bad;

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_we       (mem_we),
        .mem_a        (mem_a),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DataMemory model: combinational read, synchronous write.
    assign mem_rd = ram[mem_a[9:0]];
    always @(posedge clk) begin
        if (preload) begin
            ram[512] <= 32'd10;
            ram[513] <= 32'd0;
        end else if (mem_we) begin
            ram[mem_a[9:0]] <= mem_wd;
        end
    end

    // Issues one request and observes 8 cycles after the accept edge.
    // lat / we_at are cycle numbers after accept (0 = never seen).
    task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rdata, output logic err,
                           output int lat, output int rsp_cnt,
                           output int we_cnt, output int we_at,
                           output logic [31:0] a_first);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        lat = 0; rsp_cnt = 0; we_cnt = 0; we_at = 0;
        rdata = 32'hxxxxxxxx; err = 1'bx; a_first = 32'hxxxxxxxx;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0;
                a_first = mem_a;
            end
            if (mem_we) begin
                we_cnt++;
                if (we_at == 0) we_at = k;
            end
            if (rsp_valid) begin
                rsp_cnt++;
                if (lat == 0) begin
                    lat = k; rdata = rsp_rdata; err = rsp_err;
                end
            end
        end
        $display("txn we=%0b size=%0d uns=%0b addr=0x%08h wd=0x%08h -> rdata=0x%08h err=%0b lat=%0d we_at=%0d",
                 we, sz, uns, addr, wd, rdata, err, lat, we_at);
    endtask

    task automatic test_reset();
        preload = 1'b1;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %0b want 0", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %0b want 0", rsp_valid); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_err: got %0b want 0", rsp_err); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got 0x%08h want 0", rsp_rdata); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we: got %0b want 0", mem_we); end
        n_cmp++; if (mem_a !== 32'h0) begin n_bad++; $display("FAIL rst_mem_a: got 0x%08h want 0", mem_a); end
        n_cmp++; if (mem_wd !== 32'h0) begin n_bad++; $display("FAIL rst_mem_wd: got 0x%08h want 0", mem_wd); end
        preload = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %0b want 1", req_ready); end
        $display("txn reset done");
    endtask

    task automatic test_load_word();
        logic [31:0] rd, a1; logic er; int lat, rc, wc, wa;
        run_req(1'b0, 2'b10, 1'b0, 32'h800, 32'h0, rd, er, lat, rc, wc, wa, a1);
        n_cmp++; if (a1 !== 32'h200) begin n_bad++; $display("FAIL ldw_mem_a: got 0x%08h want 0x200", a1); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL ldw_lat: got %0d want 2", lat); end
        n_cmp++; if (rc !== 1) begin n_bad++; $display("FAIL ldw_rsp_cnt: got %0d want 1", rc); end
        n_cmp++; if (rd !== 32'h0000000A) begin n_bad++; $display("FAIL ldw_rdata: got 0x%08h want 0x0000000a", rd); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL ldw_err: got %0b want 0", er); end
        n_cmp++; if (wc !== 0) begin n_bad++; $display("FAIL ldw_we_cnt: got %0d want 0", wc); end
    endtask

    task automatic test_store_byte();
        logic [31:0] rd, a1; logic er; int lat, rc, wc, wa;
        run_req(1'b1, 2'b00, 1'b0, 32'h801, 32'h000000FF, rd, er, lat, rc, wc, wa, a1);
        n_cmp++; if (wc !== 1) begin n_bad++; $display("FAIL stb_we_cnt: got %0d want 1", wc); end
        n_cmp++; if (wa !== 2) begin n_bad++; $display("FAIL stb_we_at: got %0d want 2", wa); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL stb_lat: got %0d want 3", lat); end
        n_cmp++; if (er !== 1'b0 || rd !== 32'h0) begin n_bad++; $display("FAIL stb_rsp: got err=%0b rdata=0x%08h want 0/0", er, rd); end
        n_cmp++; if (ram[512] !== 32'h0000FF0A) begin n_bad++; $display("FAIL stb_ram: got 0x%08h want 0x0000ff0a", ram[512]); end
        run_req(1'b0, 2'b00, 1'b0, 32'h801, 32'h0, rd, er, lat, rc, wc, wa, a1);
        n_cmp++; if (rd !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL ldb_signed: got 0x%08h want 0xffffffff", rd); end
        run_req(1'b0, 2'b00, 1'b1, 32'h801, 32'h0, rd, er, lat, rc, wc, wa, a1);
        n_cmp++; if (rd !== 32'h000000FF) begin n_bad++; $display("FAIL ldb_unsigned: got 0x%08h want 0x000000ff", rd); end
        run_req(1'b0, 2'b10, 1'b0, 32'h800, 32'h0, rd, er, lat, rc, wc, wa, a1);
        n_cmp++; if (rd !== 32'h0000FF0A) begin n_bad++; $display("FAIL ldw_after_stb: got 0x%08h want 0x0000ff0a", rd); end
    endtask

    task automatic test_store_half();
        logic [31:0] rd, a1; logic er; int lat, rc, wc, wa;
        run_req(1'b1, 2'b01, 1'b0, 32'h802, 32'h0000BEEF, rd, er, lat, rc, wc, wa, a1);
        n_cmp++; if (lat !== 3 || wa !== 2 || wc !== 1) begin n_bad++; $display("FAIL sth_timing: got lat=%0d we_at=%0d we_cnt=%0d want 3/2/1", lat, wa, wc); end
        run_req(1'b0, 2'b01, 1'b0, 32'h802, 32'h0, rd, er, lat, rc, wc, wa, a1);
        n_cmp++; if (rd !== 32'hFFFFBEEF) begin n_bad++; $display("FAIL ldh_signed: got 0x%08h want 0xffffbeef", rd); end
        run_req(1'b0, 2'b10, 1'b0, 32'h800, 32'h0, rd, er, lat, rc, wc, wa, a1);
        n_cmp++; if (rd !== 32'hBEEFFF0A) begin n_bad++; $display("FAIL ldw_after_sth: got 0x%08h want 0xbeefff0a", rd); end
    endtask

    task automatic test_store_word();
        logic [31:0] rd, a1; logic er; int lat, rc, wc, wa;
        run_req(1'b1, 2'b10, 1'b0, 32'h804, 32'h12345678, rd, er, lat, rc, wc, wa, a1);
        n_cmp++; if (lat !== 2 || wa !== 1 || wc !== 1) begin n_bad++; $display("FAIL stw_timing: got lat=%0d we_at=%0d we_cnt=%0d want 2/1/1", lat, wa, wc); end
        n_cmp++; if (a1 !== 32'h201) begin n_bad++; $display("FAIL stw_mem_a: got 0x%08h want 0x201", a1); end
        run_req(1'b0, 2'b10, 1'b0, 32'h804, 32'h0, rd, er, lat, rc, wc, wa, a1);
        n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL ldw_after_stw: got 0x%08h want 0x12345678", rd); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd, a1; logic er; int lat, rc, wc, wa;
        logic [1:0]  sz_tab [3];
        logic [31:0] ad_tab [3];
        sz_tab[0] = 2'b01; ad_tab[0] = 32'h803;
        sz_tab[1] = 2'b10; ad_tab[1] = 32'h802;
        sz_tab[2] = 2'b11; ad_tab[2] = 32'h800;
        for (int i = 0; i < 3; i++) begin
            run_req(1'b1, sz_tab[i], 1'b0, ad_tab[i], 32'hA5A5A5A5, rd, er, lat, rc, wc, wa, a1);
            n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL mis%0d_lat: got %0d want 1", i, lat); end
            n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL mis%0d_rsp: got err=%0b rdata=0x%08h want 1/0", i, er, rd); end
            n_cmp++; if (wc !== 0) begin n_bad++; $display("FAIL mis%0d_we: got %0d want 0", i, wc); end
        end
        n_cmp++; if (ram[512] !== 32'hBEEFFF0A) begin n_bad++; $display("FAIL mis_ram: got 0x%08h want 0xbeefff0a", ram[512]); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd, a1; logic er; int lat, rc, wc, wa;
        int seen_we, seen_rsp;
        seen_we = 0; seen_rsp = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h800; req_wdata = 32'h00000011;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++; if (mem_a !== 32'h200) begin n_bad++; $display("FAIL midop_read_a: got 0x%08h want 0x200", mem_a); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || mem_we !== 1'b0) begin n_bad++; $display("FAIL midop_in_reset: got ready=%0b rsp=%0b we=%0b want 0/0/0", req_ready, rsp_valid, mem_we); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            if (mem_we) seen_we++;
            if (rsp_valid) seen_rsp++;
        end
        n_cmp++; if (seen_we !== 0 || seen_rsp !== 0) begin n_bad++; $display("FAIL midop_quiet: got we=%0d rsp=%0d want 0/0", seen_we, seen_rsp); end
        n_cmp++; if (ram[512] !== 32'hBEEFFF0A) begin n_bad++; $display("FAIL midop_ram: got 0x%08h want 0xbeefff0a", ram[512]); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL midop_ready: got %0b want 1", req_ready); end
        run_req(1'b0, 2'b10, 1'b0, 32'h800, 32'h0, rd, er, lat, rc, wc, wa, a1);
        n_cmp++; if (rd !== 32'hBEEFFF0A || lat !== 2) begin n_bad++; $display("FAIL midop_reload: got 0x%08h lat=%0d want 0xbeefff0a lat=2", rd, lat); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  sz_tab [3];
        logic        un_tab [3];
        logic [31:0] ad_tab [3];
        logic [31:0] ex_tab [3];
        int acc [3];
        int idx, rsp_n;
        sz_tab[0] = 2'b10; un_tab[0] = 1'b0; ad_tab[0] = 32'h800; ex_tab[0] = 32'hBEEFFF0A;
        sz_tab[1] = 2'b00; un_tab[1] = 1'b1; ad_tab[1] = 32'h803; ex_tab[1] = 32'h000000BE;
        sz_tab[2] = 2'b01; un_tab[2] = 1'b0; ad_tab[2] = 32'h800; ex_tab[2] = 32'hFFFFFF0A;
        idx = 0; rsp_n = 0;
        acc[0] = 0; acc[1] = 0; acc[2] = 0;
        @(negedge clk);
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (rsp_valid) begin
                if (rsp_n < 3) begin
                    n_cmp++; if (rsp_rdata !== ex_tab[rsp_n] || rsp_err !== 1'b0) begin n_bad++; $display("FAIL b2b%0d_rdata: got 0x%08h err=%0b want 0x%08h err=0", rsp_n, rsp_rdata, rsp_err, ex_tab[rsp_n]); end
                    $display("txn b2b rsp %0d rdata=0x%08h at cycle %0d", rsp_n, rsp_rdata, cyc);
                end
                rsp_n++;
            end
            if (req_ready) begin
                if (idx < 3) begin
                    acc[idx] = cyc;
                    req_valid = 1'b1; req_we = 1'b0; req_size = sz_tab[idx];
                    req_unsigned = un_tab[idx]; req_addr = ad_tab[idx]; req_wdata = 32'h0;
                    idx++;
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        n_cmp++; if (acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3) begin n_bad++; $display("FAIL b2b_spacing: got %0d,%0d want 3,3", acc[1] - acc[0], acc[2] - acc[1]); end
        n_cmp++; if (rsp_n !== 3) begin n_bad++; $display("FAIL b2b_rsp_cnt: got %0d want 3", rsp_n); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_load_word();
        test_store_byte();
        test_store_half();
        test_store_word();
        test_misaligned();
        test_reset_midop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
